// File: rtl/lc3b_types.sv
// Shared SLC-3 types: datapath word, SRAM arbiter state, port select and transfer payload.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_arb_state;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } mem_arb_port;

  // One SRAM transfer as latched at grant time.
  typedef struct packed {
    logic     we;
    lc3b_word addr;
    lc3b_word wdata;
  } mem_arb_xfer;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner select; a tie goes to the port not granted last.
module mem_arb_pick
  import lc3b_types::*;
(
  input  logic        cpu_req,
  input  logic        dbg_req,
  input  mem_arb_port last,
  output logic        any_c,
  output mem_arb_port winner_c
);

  always_comb begin
    any_c    = cpu_req | dbg_req;
    winner_c = PORT_CPU;
    if (cpu_req && dbg_req) begin
      winner_c = (last == PORT_DBG) ? PORT_CPU : PORT_DBG;
    end else if (dbg_req) begin
      winner_c = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DBG arbiter and fixed-length access sequencer for the shared asynchronous SRAM.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU always wins ties.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [WORD_W-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_wdata,
  output logic [WORD_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              grant_dbg,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam int unsigned       CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  mem_arb_state      state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  mem_arb_xfer       xfer, xfer_nxt;
  mem_arb_port       port, port_nxt;
  lc3b_word          cpu_rdata_nxt, dbg_rdata_nxt;
  logic              ce_nxt, oe_nxt, we_nxt, data_oe_nxt, cpu_ack_nxt, dbg_ack_nxt;
  logic              any_c;
  mem_arb_port       winner_c;

`ifdef MEM_ARB_RR_EN
  mem_arb_port       last, last_nxt;
`else
  mem_arb_port       last;
  assign last = PORT_DBG;
`endif

  mem_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .last     (last),
    .any_c    (any_c),
    .winner_c (winner_c)
  );

  // State register, latched transfer, counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      xfer        <= '0;
      port        <= PORT_CPU;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      Mem_CE      <= 1'b1;
      Mem_UB      <= 1'b1;
      Mem_LB      <= 1'b1;
      Mem_OE      <= 1'b1;
      Mem_WE      <= 1'b1;
      mem_data_oe <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last        <= PORT_DBG;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      xfer        <= xfer_nxt;
      port        <= port_nxt;
      cpu_rdata   <= cpu_rdata_nxt;
      dbg_rdata   <= dbg_rdata_nxt;
      Mem_CE      <= ce_nxt;
      Mem_UB      <= ce_nxt;
      Mem_LB      <= ce_nxt;
      Mem_OE      <= oe_nxt;
      Mem_WE      <= we_nxt;
      mem_data_oe <= data_oe_nxt;
      cpu_ack     <= cpu_ack_nxt;
      dbg_ack     <= dbg_ack_nxt;
`ifdef MEM_ARB_RR_EN
      last        <= last_nxt;
`endif
    end
  end

  // Next state: grant in IDLE, count down the strobe window, capture read data on exit.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    xfer_nxt      = xfer;
    port_nxt      = port;
    cpu_rdata_nxt = cpu_rdata;
    dbg_rdata_nxt = dbg_rdata;
`ifdef MEM_ARB_RR_EN
    last_nxt      = last;
`endif
    case (state)
      IDLE: begin
        if (any_c) begin
          port_nxt = winner_c;
          if (winner_c == PORT_DBG) begin
            xfer_nxt = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
          end else begin
            xfer_nxt = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          end
          cnt_nxt   = CNT_LOAD;
          state_nxt = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_nxt  = winner_c;
`endif
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          if (!xfer.we) begin
            if (port == PORT_DBG) dbg_rdata_nxt = mem_rdata;
            else                  cpu_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    ce_nxt      = 1'b1;
    oe_nxt      = 1'b1;
    we_nxt      = 1'b1;
    data_oe_nxt = 1'b0;
    cpu_ack_nxt = 1'b0;
    dbg_ack_nxt = 1'b0;
    case (state_nxt)
      ACCESS: begin
        ce_nxt      = 1'b0;
        oe_nxt      = xfer_nxt.we;
        we_nxt      = !xfer_nxt.we;
        data_oe_nxt = xfer_nxt.we;
      end
      DONE: begin
        data_oe_nxt = xfer_nxt.we;
        cpu_ack_nxt = (port_nxt == PORT_CPU);
        dbg_ack_nxt = (port_nxt == PORT_DBG);
      end
      default: ;
    endcase
  end

  assign mem_addr  = xfer.addr;
  assign mem_wdata = xfer.wdata;
  assign grant_dbg = (port == PORT_DBG);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timing reference model and SRAM model.
module tb_mem_arbiter;

  localparam int unsigned AC = 2;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack, grant_dbg;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .grant_dbg(grant_dbg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  // Short and long strobe-window instances, CPU port only.
  logic        l1_req, l1_ack, l1_dack, l1_gnt, l1_doe, l1_ce, l1_ub, l1_lb, l1_oe, l1_we;
  logic [15:0] l1_crd, l1_drd, l1_ma, l1_mw;
  logic        l15_req, l15_ack, l15_dack, l15_gnt, l15_doe, l15_ce, l15_ub, l15_lb, l15_oe, l15_we;
  logic [15:0] l15_crd, l15_drd, l15_ma, l15_mw;

  mem_arbiter #(.ACCESS_CYCLES(1)) u_lat1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(l1_req), .cpu_we(1'b0), .cpu_addr(16'h0), .cpu_wdata(16'h0),
    .cpu_rdata(l1_crd), .cpu_ack(l1_ack),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_rdata(l1_drd), .dbg_ack(l1_dack), .grant_dbg(l1_gnt),
    .mem_addr(l1_ma), .mem_wdata(l1_mw), .mem_data_oe(l1_doe), .mem_rdata(16'h0),
    .Mem_CE(l1_ce), .Mem_UB(l1_ub), .Mem_LB(l1_lb), .Mem_OE(l1_oe), .Mem_WE(l1_we)
  );

  mem_arbiter #(.ACCESS_CYCLES(15)) u_lat15 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(l15_req), .cpu_we(1'b0), .cpu_addr(16'h0), .cpu_wdata(16'h0),
    .cpu_rdata(l15_crd), .cpu_ack(l15_ack),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_rdata(l15_drd), .dbg_ack(l15_dack), .grant_dbg(l15_gnt),
    .mem_addr(l15_ma), .mem_wdata(l15_mw), .mem_data_oe(l15_doe), .mem_rdata(16'h0),
    .Mem_CE(l15_ce), .Mem_UB(l15_ub), .Mem_LB(l15_lb), .Mem_OE(l15_oe), .Mem_WE(l15_we)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Asynchronous SRAM model; a reset clears it so the reference memory can follow.
  logic [15:0] sram [0:1023];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
    end else if (!Mem_CE && !Mem_WE && mem_data_oe) begin
      sram[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (!Mem_CE && !Mem_OE) ? sram[mem_addr[9:0]] : 16'hDEAD;

  // Reference model: a granted transfer owns the bus for cycles t0+1..t0+AC+1.
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          t0 = 0;
  int          ph;
  bit          busy = 1'b0;
  bit          was_busy;
  bit          m_port = 1'b0;
  bit          m_we = 1'b0;
  bit          m_last = 1'b1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};
  logic [15:0] ref_mem [0:1023];
  bit          ack_log [$];
  bit          e_ce, e_oe, e_we, e_doe, e_cack, e_dack;

  always @(negedge Clk) begin
    if (mon_en) begin
      e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_cack = 0; e_dack = 0;
      was_busy = busy;
      if (busy) begin
        ph = cyc - t0;
        if (ph <= int'(AC)) begin
          e_ce = 0; e_oe = m_we; e_we = !m_we; e_doe = m_we;
        end else begin
          e_doe = m_we;
          if (m_port) e_dack = 1; else e_cack = 1;
          if (m_we) ref_mem[m_addr[9:0]] = m_wdata;
          else      m_rd[m_port] = ref_mem[m_addr[9:0]];
          busy = 0;
        end
        check("grant_dbg", 32'(grant_dbg), 32'(m_port));
      end
      check("Mem_CE", 32'(Mem_CE), 32'(e_ce));
      check("Mem_UB", 32'(Mem_UB), 32'(e_ce));
      check("Mem_LB", 32'(Mem_LB), 32'(e_ce));
      check("Mem_OE", 32'(Mem_OE), 32'(e_oe));
      check("Mem_WE", 32'(Mem_WE), 32'(e_we));
      check("mem_data_oe", 32'(mem_data_oe), 32'(e_doe));
      check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
      check("dbg_ack", 32'(dbg_ack), 32'(e_dack));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_rd[0]));
      check("dbg_rdata", 32'(dbg_rdata), 32'(m_rd[1]));
      if (cpu_ack) ack_log.push_back(1'b0);
      if (dbg_ack) ack_log.push_back(1'b1);
      if (Reset) begin
        busy = 0; m_port = 0; m_we = 0; m_last = 1; m_addr = '0; m_wdata = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      end else if (!was_busy && (cpu_req || dbg_req)) begin
`ifdef MEM_ARB_RR_EN
        m_port = (cpu_req && dbg_req) ? !m_last : !cpu_req;
`else
        m_port = !cpu_req;
`endif
        m_last  = m_port;
        m_we    = m_port ? dbg_we : cpu_we;
        m_addr  = m_port ? dbg_addr : cpu_addr;
        m_wdata = m_port ? dbg_wdata : cpu_wdata;
        t0      = cyc;
        busy    = 1;
      end
      cyc++;
    end
  end

  task automatic drive(input bit p, input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (p) begin dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else   begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
  endtask

  // One request on port p, held until its ack; wiggle perturbs addr/data after the first cycle.
  task automatic txn(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                     input bit keep, input bit wiggle, output logic [15:0] rd);
    bit got = 0;
    rd = '0;
    @(posedge Clk); #1;
    drive(p, 1'b1, we, a, d);
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      if (p ? dbg_ack : cpu_ack) begin
        got = 1;
        rd  = p ? dbg_rdata : cpu_rdata;
        break;
      end
      if (wiggle) begin
        @(posedge Clk); #1;
        drive(p, 1'b1, we, a ^ 16'h0001, d ^ 16'hFFFF);
      end
    end
    check(p ? "dbg_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    if (!keep) begin
      @(posedge Clk); #1;
      drive(p, 1'b0, we, a, d);
    end
  endtask

  task automatic rand_port(input bit p);
    bit keep = 0;
    logic [15:0] rd;
    for (int i = 0; i < 30; i++) begin
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge Clk);
      keep = (i != 29) && ($urandom_range(0, 1) == 1);
      txn(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), keep,
          1'($urandom_range(0, 1)), rd);
    end
  endtask

  // Cycle 0 is the cycle in which req is first sampled.
  task automatic lat(input bit long_win, output int ack_at, output int low);
    ack_at = -1;
    low    = 0;
    @(posedge Clk); #1;
    if (long_win) l15_req = 1; else l1_req = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (!(long_win ? l15_ce : l1_ce)) low++;
      if (long_win ? l15_ack : l1_ack) begin
        ack_at = c;
        break;
      end
    end
    @(posedge Clk); #1;
    l1_req = 0; l15_req = 0;
  endtask

  initial begin
    logic [15:0] rd;
    int ack_at, low;
    Reset = 1;
    l1_req = 0; l15_req = 0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge Clk); #1 mon_en = 1;
    @(posedge Clk); #1 Reset = 0;

    // Both ports requesting continuously for four transactions.
    ack_log.delete();
    drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (ack_log.size() >= 4) break;
    end
    @(posedge Clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0);
    check("ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      check("ack_order", 32'(ack_log[i]), 32'(i % 2));
`else
      check("ack_order", 32'(ack_log[i]), 32'd0);
`endif
    end
    repeat (4) @(posedge Clk);

    txn(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, 1'b0, rd);
    txn(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, rd);
    check("cpu_rd_0030", 32'(rd), 32'h1234);
    txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, rd);
    txn(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, rd);
    check("cpu_rd_0100", 32'(rd), 32'hBEEF);
    txn(1'b0, 1'b1, 16'h0031, 16'h5555, 1'b0, 1'b0, rd);
    txn(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1, rd);
    check("cpu_rd_addr_change", 32'(rd), 32'h1234);
    txn(1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 1'b0, rd);
    check("dbg_rd_0031", 32'(rd), 32'h5555);
    repeat (3) @(posedge Clk);

    // Reset during the first ACCESS cycle of a write.
    #1 drive(1'b0, 1'b1, 1'b1, 16'h0200, 16'hA5A5);
    @(posedge Clk); #1 Reset = 1; drive(1'b0, 1'b0, 1'b1, 16'h0200, 16'hA5A5);
    @(posedge Clk); #1 Reset = 0;
    @(negedge Clk);
    check("rst_Mem_WE", 32'(Mem_WE), 32'd1);
    check("rst_Mem_CE", 32'(Mem_CE), 32'd1);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    txn(1'b0, 1'b1, 16'h0200, 16'hA5A5, 1'b0, 1'b0, rd);
    txn(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, rd);
    check("dbg_rd_0200", 32'(rd), 32'hA5A5);

    lat(1'b0, ack_at, low);
    check("lat1_ack_cycle", 32'(ack_at), 32'd2);
    check("lat1_strobe_width", 32'(low), 32'd1);
    lat(1'b1, ack_at, low);
    check("lat15_ack_cycle", 32'(ack_at), 32'd16);
    check("lat15_strobe_width", 32'(low), 32'd15);

    fork
      rand_port(1'b0);
      rand_port(1'b1);
    join
    repeat (6) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
